// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci result BCD converter.
// Holds default widths, the converter state encoding, the captured status
// record and the per-digit double-dabble adjust helper.
package fib_pkg;

    localparam int FIB_DATA_WIDTH  = 64;
    localparam int FIB_ORDER_WIDTH = 16;
    localparam int FIB_BCD_DIGITS  = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } bcd_state_t;

    typedef struct packed {
        logic error;
        logic overflow;
    } fib_status_t;

    // Double-dabble correction: a digit of 5 or more gets 3 added so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] digit);
        logic [3:0] adj;
        if (digit >= 4'd5) begin
            adj = digit + 4'd3;
        end else begin
            adj = digit;
        end
        return adj;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: adjust every BCD digit, then shift the whole
// accumulator left by one with bit_in entering digit 0. The carry out of the
// top digit is discarded; DIGITS is sized so it is always zero.
module bcd_dabble_step
    import fib_pkg::*;
#(
    parameter int DIGITS = FIB_BCD_DIGITS
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_out
);

    logic       carry_s;
    logic [3:0] digit_s;

    // Adjust each digit and chain its MSB into the next digit's LSB.
    always_comb begin
        bcd_out = '0;
        carry_s = bit_in;
        digit_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_s            = dabble_adjust(bcd_in[4*i +: 4]);
            bcd_out[4*i +: 4]  = {digit_s[2:0], carry_s};
            carry_s            = digit_s[3];
        end
    end

endmodule

// File: rtl/fib_result_bcd.sv
// Captures each finished Fibonacci result on the rising edge of done and
// converts it to packed BCD with one double-dabble step per clock, then
// presents the record over a valid/ready handshake. Results flagged with
// error or overflow skip conversion and are returned with a zero value.
// Optional statistics counters are enabled with FIB_BCD_STATS_EN.
module fib_result_bcd
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH  = FIB_DATA_WIDTH,
    parameter int ORDER_WIDTH = FIB_ORDER_WIDTH,
    parameter int DIGITS      = FIB_BCD_DIGITS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   done,
    input  logic                   error,
    input  logic                   overflow,
    input  logic [ORDER_WIDTH-1:0] order,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   bcd_ready,
    output logic                   bcd_valid,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic [ORDER_WIDTH-1:0] out_order,
    output logic                   out_error,
    output logic                   out_overflow,
    output logic                   busy,
    output logic                   dropped
`ifdef FIB_BCD_STATS_EN
    ,
    output logic [15:0]            drop_count,
    output logic [15:0]            err_count,
    output logic [15:0]            ovf_count
`endif
);

    localparam int            CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    bcd_state_t             state_r;
    logic                   done_q_r;
    logic [DATA_WIDTH-1:0]  bin_r;
    logic [4*DIGITS-1:0]    acc_r;
    logic [4*DIGITS-1:0]    step_s;
    logic [CW-1:0]          cnt_r;
    fib_status_t            status_s;
    logic                   capture_ev_s;
    logic                   can_take_s;
    logic                   take_s;
    logic                   drop_s;

    assign status_s     = '{error: error, overflow: overflow};
    assign capture_ev_s = done & ~done_q_r;
    // A new result fits only when idle or when the held record leaves this cycle.
    assign can_take_s   = (state_r == IDLE) | ((state_r == HOLD) & bcd_ready);
    assign take_s       = capture_ev_s & can_take_s;
    assign drop_s       = capture_ev_s & ~can_take_s;

    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_in  (acc_r),
        .bit_in  (bin_r[DATA_WIDTH-1]),
        .bcd_out (step_s)
    );

    // Converter FSM: capture, iterative conversion and output hold.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_r      <= IDLE;
            done_q_r     <= 1'b0;
            bin_r        <= '0;
            acc_r        <= '0;
            cnt_r        <= '0;
            bcd_valid    <= 1'b0;
            bcd_out      <= '0;
            out_order    <= '0;
            out_error    <= 1'b0;
            out_overflow <= 1'b0;
            busy         <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            done_q_r <= done;
            dropped  <= drop_s;
            if (take_s) begin
                out_order    <= order;
                out_error    <= status_s.error;
                out_overflow <= status_s.overflow;
                busy         <= 1'b1;
                if (status_s.error | status_s.overflow) begin
                    // Flagged results are not meaningful numbers; report zero.
                    state_r   <= HOLD;
                    bcd_out   <= '0;
                    bcd_valid <= 1'b1;
                end else begin
                    state_r   <= SHIFT;
                    bin_r     <= data_in;
                    acc_r     <= '0;
                    cnt_r     <= CNT_LOAD;
                    bcd_valid <= 1'b0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    SHIFT: begin
                        acc_r <= step_s;
                        bin_r <= {bin_r[DATA_WIDTH-2:0], 1'b0};
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r   <= HOLD;
                            bcd_out   <= step_s;
                            bcd_valid <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (bcd_ready) begin
                            state_r   <= IDLE;
                            bcd_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        bcd_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FIB_BCD_STATS_EN
    // Saturating event counters for dropped results and captured flags.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            drop_count <= 16'h0000;
            err_count  <= 16'h0000;
            ovf_count  <= 16'h0000;
        end else begin
            if (drop_s && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            if (take_s && status_s.error && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (take_s && status_s.overflow && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fib_result_bcd.sv
// Self-checking bench for fib_result_bcd: a transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, and a
// randomized phase.
module tb_fib_result_bcd;

    localparam int DW = 64;
    localparam int OW = 16;
    localparam int ND = 20;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            done;
    logic            error;
    logic            overflow;
    logic [OW-1:0]   order;
    logic [DW-1:0]   data_in;
    logic            bcd_ready;
    logic            bcd_valid;
    logic [4*ND-1:0] bcd_out;
    logic [OW-1:0]   out_order;
    logic            out_error;
    logic            out_overflow;
    logic            busy;
    logic            dropped;
`ifdef FIB_BCD_STATS_EN
    logic [15:0]     drop_count;
    logic [15:0]     err_count;
    logic [15:0]     ovf_count;
`endif

    always #5 clk = ~clk;

    fib_result_bcd dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .done         (done),
        .error        (error),
        .overflow     (overflow),
        .order        (order),
        .data_in      (data_in),
        .bcd_ready    (bcd_ready),
        .bcd_valid    (bcd_valid),
        .bcd_out      (bcd_out),
        .out_order    (out_order),
        .out_error    (out_error),
        .out_overflow (out_overflow),
        .busy         (busy),
        .dropped      (dropped)
`ifdef FIB_BCD_STATS_EN
        ,
        .drop_count   (drop_count),
        .err_count    (err_count),
        .ovf_count    (ovf_count)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain decimal conversion by repeated division.
    function automatic logic [79:0] to_bcd(input logic [63:0] v);
        logic [79:0] r;
        logic [63:0] x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 64'd10);
            x = x / 64'd10;
        end
        return r;
    endfunction

    // Reference model: what the outputs must be after each clock edge.
    int          m_conv;
    bit          m_valid, m_drop, m_rst, m_done_q, m_err, m_ovf;
    logic [79:0] m_bcd, m_pend;
    logic [15:0] m_order;
    int          m_drops, m_errs, m_ovfs;
    bit          m_ev, m_can;

    always @(posedge clk) begin
        if (reset_n) begin
            m_conv = 0; m_valid = 0; m_drop = 0; m_rst = 1; m_done_q = 0;
            m_err = 0; m_ovf = 0; m_bcd = '0; m_pend = '0; m_order = '0;
            m_drops = 0; m_errs = 0; m_ovfs = 0;
        end else begin
            m_rst    = 0;
            m_ev     = done && !m_done_q;
            m_done_q = done;
            m_drop   = 0;
            m_can    = (m_conv == 0 && !m_valid) || (m_valid && bcd_ready);
            if (m_valid && bcd_ready) m_valid = 0;
            if (m_conv > 0) begin
                m_conv--;
                if (m_conv == 0) begin
                    m_valid = 1;
                    m_bcd   = m_pend;
                end
            end
            if (m_ev) begin
                if (m_can) begin
                    m_order = order;
                    m_err   = error;
                    m_ovf   = overflow;
                    if (error || overflow) begin
                        m_valid = 1;
                        m_bcd   = '0;
                    end else begin
                        m_conv = DW;
                        m_pend = to_bcd(data_in);
                    end
                    if (error && m_errs < 65535) m_errs++;
                    if (overflow && m_ovfs < 65535) m_ovfs++;
                end else begin
                    m_drop = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("bcd_valid", bcd_valid, m_valid);
            chk("busy", busy, (m_conv > 0) || m_valid);
            chk("dropped", dropped, m_drop);
            if (m_valid) begin
                chk("bcd_out", bcd_out, m_bcd);
                chk("out_order", out_order, m_order);
                chk("out_error", out_error, m_err);
                chk("out_overflow", out_overflow, m_ovf);
            end
            if (m_rst) begin
                chk("rst_bcd_out", bcd_out, 80'd0);
                chk("rst_out_order", out_order, 80'd0);
                chk("rst_out_error", out_error, 80'd0);
                chk("rst_out_overflow", out_overflow, 80'd0);
            end
`ifdef FIB_BCD_STATS_EN
            chk("drop_count", drop_count, m_drops);
            chk("err_count", err_count, m_errs);
            chk("ovf_count", ovf_count, m_ovfs);
`endif
        end
    end

    task automatic launch(input logic [63:0] d, input logic [15:0] o, input bit e, input bit v);
        data_in  = d;
        order    = o;
        error    = e;
        overflow = v;
        done     = 1'b1;
    endtask

    // Count falling edges until bcd_valid, releasing done after 'hold' edges.
    task automatic wait_valid(input int maxc, input int hold, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == hold) done = 1'b0;
        end while (!bcd_valid && n < maxc);
        if (!bcd_valid) begin
            total++;
            bad++;
            $display("FAIL timeout: bcd_valid still low after %0d cycles", n);
        end
        done = 1'b0;
    endtask

    task automatic accept();
        bcd_ready = 1'b1;
        @(negedge clk);
        bcd_ready = 1'b0;
    endtask

    int n;

    initial begin
        reset_n = 1'b1; done = 1'b0; error = 1'b0; overflow = 1'b0;
        order = '0; data_in = '0; bcd_ready = 1'b0;
        repeat (3) @(negedge clk);
        run_chk = 1'b1;
        chk("reset_valid", bcd_valid, 80'd0);
        chk("reset_busy", busy, 80'd0);
        reset_n = 1'b0;
        @(negedge clk);

        // 55 with done held high for several cycles: one capture only.
        launch(64'd55, 16'd10, 1'b0, 1'b0);
        wait_valid(200, 4, n);
        chk("lat_shift", n, 80'd65);
        chk("bcd_55", bcd_out, 80'h55);
        chk("order_10", out_order, 80'd10);
        accept();

        // Largest value and zero.
        launch(64'hFFFF_FFFF_FFFF_FFFF, 16'd1, 1'b0, 1'b0);
        wait_valid(200, 1, n);
        chk("bcd_max", bcd_out, 80'h18446744073709551615);
        accept();
        launch(64'd0, 16'd2, 1'b0, 1'b0);
        wait_valid(200, 1, n);
        chk("bcd_zero", bcd_out, 80'd0);
        accept();

        // Overflow result bypasses conversion.
        launch(64'h1234, 16'd94, 1'b0, 1'b1);
        wait_valid(10, 1, n);
        chk("lat_flag", n, 80'd1);
        chk("ovf_flag", out_overflow, 80'd1);
        chk("ovf_bcd", bcd_out, 80'd0);
        chk("ovf_order", out_order, 80'd94);
        accept();

        // Second edge mid-conversion is dropped; first result survives.
        launch(64'd12200160415121876738, 16'd93, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) done = 1'b0;
        end
        launch(64'd1, 16'd5, 1'b0, 1'b0);
        @(negedge clk);
        done = 1'b0;
        chk("drop_pulse", dropped, 80'd1);
        @(negedge clk);
        chk("drop_once", dropped, 80'd0);
        wait_valid(200, 0, n);
        chk("bcd_fib93", bcd_out, 80'h12200160415121876738);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_bcd", bcd_out, 80'h12200160415121876738);
            chk("hold_order", out_order, 80'd93);
        end
        // Back-to-back capture in the accepting cycle.
        launch(64'd987, 16'd17, 1'b0, 1'b0);
        bcd_ready = 1'b1;
        @(negedge clk);
        done = 1'b0;
        bcd_ready = 1'b0;
        chk("b2b_busy", busy, 80'd1);
        chk("b2b_valid", bcd_valid, 80'd0);
        wait_valid(200, 0, n);
        chk("b2b_lat", n, 80'd64);
        chk("bcd_987", bcd_out, 80'h987);
        accept();

        // Reset in the middle of a conversion.
        launch(64'd777, 16'd3, 1'b0, 1'b0);
        @(negedge clk);
        done = 1'b0;
        repeat (29) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        chk("abort_valid", bcd_valid, 80'd0);
        chk("abort_busy", busy, 80'd0);
        chk("abort_bcd", bcd_out, 80'd0);
        launch(64'd12345, 16'd4, 1'b0, 1'b0);
        wait_valid(200, 1, n);
        chk("lat_after_rst", n, 80'd65);
        chk("bcd_12345", bcd_out, 80'h12345);
        accept();

        // Randomized traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset_n   = ($urandom_range(0, 999) == 0);
            bcd_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) done = ~done;
            error    = ($urandom_range(0, 5) == 0);
            overflow = ($urandom_range(0, 5) == 0);
            order    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data_in = 64'($urandom_range(0, 999));
            else data_in = {$urandom, $urandom};
        end
        reset_n = 1'b0; done = 1'b0; bcd_ready = 1'b1;
        repeat (100) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_result_bcd.md
Name: fib_result_bcd

Overview:
- Downstream consumer of the Fibonacci number generator: captures each finished result and converts the binary value to packed BCD for display/log.
- Returns the BCD value, its order and status flags over a valid/ready handshake.
- Conversion is iterative double-dabble, one bit per clock.

Parameters:
- DATA_WIDTH, 64, width of binary result from generator
- ORDER_WIDTH, 16, width of order/position field
- DIGITS, 20, number of BCD digits; must satisfy 10^DIGITS > 2^DATA_WIDTH-1

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-high reset (1 = reset, sampled on clk)
- done  in  1  generator done level
- error  in  1  generator error flag, valid while done high
- overflow  in  1  generator overflow flag, valid while done high
- order  in  ORDER_WIDTH  order of the result, valid while done high
- data_in  in  DATA_WIDTH  generator data_out
- bcd_ready  in  1  consumer accepts output
- bcd_valid  out  1  output record valid
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in [3:0]
- out_order  out  ORDER_WIDTH  captured order
- out_error  out  1  captured error
- out_overflow  out  1  captured overflow
- busy  out  1  state != IDLE
- dropped  out  1  one-cycle pulse: result lost

Behaviour:
- Reset: all outputs 0, state IDLE, done edge register 0. Reset mid-operation aborts conversion; no partial output is produced.
- Capture event: done=1 and done_q=0, i.e. a rising edge detected with a registered done_q.
- Capture allowed in IDLE, or in HOLD in the same cycle the current record is accepted (bcd_valid && bcd_ready).
- Capture event in SHIFT, or in HOLD without acceptance: pulse dropped for 1 cycle; the current record is unaffected.
- States:
  - IDLE -> SHIFT on capture with error=0 and overflow=0. Load shift register = data_in, BCD accumulator = 0, bit counter = DATA_WIDTH.
  - IDLE -> HOLD on capture with error or overflow set. bcd_out = 0 and flags latched; no conversion is run.
  - SHIFT: each cycle, add 3 to every digit >= 5, then shift {bcd, bin} left 1; decrement counter. When the counter reaches 1, go to HOLD next cycle.
  - HOLD: bcd_valid=1, and all out_* are stable until accepted. On bcd_valid && bcd_ready, go to IDLE (or capture per the rule above).
- Latency: capture edge at cycle N -> bcd_valid high at cycle N+DATA_WIDTH+1. Error/overflow path: bcd_valid at N+1.
- Width rules: the accumulator never exceeds 4*DIGITS bits. For data_in = 0, output is all-zero digits.
- done held high across multiple cycles yields one capture only.

Optional Feature:
- Macro FIB_BCD_STATS_EN.
- Defined: add outputs drop_count[15:0], err_count[15:0], ovf_count[15:0].
  - drop_count increments on each dropped pulse; err_count and ovf_count increment on each captured record with that flag set.
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package fib_pkg:
  - FIB_DATA_WIDTH=64, FIB_ORDER_WIDTH=16, FIB_BCD_DIGITS=20
  - state enum bcd_state_t {IDLE, SHIFT, HOLD}
  - struct fib_status_t {error, overflow}
- Sub-module bcd_dabble_step: combinational add-3-and-shift over DIGITS digits plus the incoming bit; instantiated once.

Test Plan:
- Capture data_in=55, order=10, flags 0 -> after 65 cycles bcd_valid=1, bcd_out low byte 8'h55, upper digits 0, out_order=10.
- data_in=64'hFFFF_FFFF_FFFF_FFFF -> bcd_out = 18446744073709551615 digitwise; data_in=0 -> all zero digits.
- Capture with overflow=1, order=94 -> bcd_valid next cycle, out_overflow=1, bcd_out=0, no SHIFT cycles.
- Second done edge 10 cycles into SHIFT -> dropped pulses once, first result (Fib(93)=12200160415121876738) emitted intact. Hold bcd_ready=0 for 20 cycles -> outputs stable; a new edge with ready=1 in HOLD is captured back-to-back.
- reset_n=1 at cycle 30 of a conversion -> next cycle all outputs 0, IDLE; a subsequent capture converts correctly.
- With FIB_BCD_STATS_EN: 3 drops, 2 errors -> drop_count=3, err_count=2; reset clears all counters.
